// File: rtl/regfile_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_arbiter
//
// Shares the single port of a small register file (one write port,
// combinational read) among NUM_REQ client engines. Clients are served
// round-robin. A client may ask to keep the grant (req_lock) for a bounded
// run of back-to-back accesses.
//
// Ports:
//   clock, reset   rising-edge clock, synchronous active-high reset
//   req_valid      per-requester request valid (held until accepted)
//   req_ready      per-requester accept, one-hot or zero (combinational)
//   req_write      1 = write, 0 = read
//   req_lock       ask to keep the grant for the following access
//   req_addr       packed addresses, requester i in slice i
//   req_wdata      packed write data, requester i in slice i
//   rf_valid       register-file write enable (registered)
//   rf_addr        register-file address for reads and writes (registered)
//   rf_data_in     register-file write data (registered)
//   rf_rdata       register-file combinational read data
//   rsp_valid      one-cycle read-response strobe, one-hot or zero
//   rsp_data       read data, meaningful while any rsp_valid bit is high
//
// Timing: an access accepted in cycle T is presented to the register file
// in T+1; for a read, rf_rdata is captured at the end of T+1 and returned
// to the issuing requester in T+2.
// ---------------------------------------------------------------------------
module regfile_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ADDR_W   = 3,
    parameter int DATA_W   = 8,
    parameter int MAX_LOCK = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ-1:0]          req_write,
    input  logic [NUM_REQ-1:0]          req_lock,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
    output logic                        rf_valid,
    output logic [ADDR_W-1:0]           rf_addr,
    output logic [DATA_W-1:0]           rf_data_in,
    input  logic [DATA_W-1:0]           rf_rdata,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]           rsp_data
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_LOCK + 1);

    localparam logic [CNT_W-1:0] MAX_LOCK_C = CNT_W'(MAX_LOCK);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_REQ - 1);
    // With a single-grant limit a lock could never extend a run.
    localparam logic             LOCK_EN    = (MAX_LOCK > 1);

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;          // last granted requester
    logic [IDX_W-1:0]   owner_q, owner_d;      // lock owner while LOCKED
    logic [CNT_W-1:0]   lock_cnt_q, lock_cnt_d;

    logic               rf_valid_q, rf_valid_d;
    logic [ADDR_W-1:0]  rf_addr_q, rf_addr_d;
    logic [DATA_W-1:0]  rf_data_in_q, rf_data_in_d;
    logic [NUM_REQ-1:0] rd_pend_q, rd_pend_d;  // read issued this cycle, by whom
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;

    // -----------------------------------------------------------------------
    // Unpack the per-requester fields
    // -----------------------------------------------------------------------
    logic [ADDR_W-1:0] addr_arr  [NUM_REQ];
    logic [DATA_W-1:0] wdata_arr [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
        assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
    end

    // -----------------------------------------------------------------------
    // Round-robin search: first valid requester after the pointer, wrapping.
    // -----------------------------------------------------------------------
    logic             rr_found;
    logic [IDX_W-1:0] rr_idx;
    logic [IDX_W-1:0] rr_cand;

    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        rr_cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            rr_cand = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
            if (!rr_found && req_valid[rr_cand]) begin
                rr_found = 1'b1;
                rr_idx   = rr_cand;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Grant selection. The lock only wins while its owner is still asking and
    // the run limit has not been reached; otherwise this very cycle falls back
    // to round-robin from the owner's position, so the owner goes last.
    // -----------------------------------------------------------------------
    logic             lock_hold;
    logic             grant_any;
    logic [IDX_W-1:0] grant_idx;
    logic [CNT_W-1:0] cnt_inc;

    always_comb begin
        lock_hold = (state_q == LOCKED) && req_valid[owner_q]
                    && (lock_cnt_q < MAX_LOCK_C);
        grant_any = lock_hold || rr_found;
        grant_idx = lock_hold ? owner_q : rr_idx;
        cnt_inc   = lock_cnt_q + CNT_W'(1);
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
        assign req_ready[gi] = grant_any && (grant_idx == IDX_W'(gi));
    end

    // -----------------------------------------------------------------------
    // Arbitration FSM next state
    // -----------------------------------------------------------------------
    always_comb begin
        // Idle cycles (and any cycle without a continuing lock) land in ARB.
        state_d    = ARB;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        lock_cnt_d = '0;

        if (lock_hold) begin
            ptr_d = owner_q;
            // A lock request on the final permitted grant is ignored.
            if (req_lock[owner_q] && (cnt_inc < MAX_LOCK_C)) begin
                state_d    = LOCKED;
                lock_cnt_d = cnt_inc;
            end
        end else if (rr_found) begin
            ptr_d = rr_idx;
            if (LOCK_EN && req_lock[rr_idx]) begin
                state_d    = LOCKED;
                owner_d    = rr_idx;
                lock_cnt_d = CNT_W'(1);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Issue and response pipeline
    // -----------------------------------------------------------------------
    always_comb begin
        rf_valid_d   = 1'b0;
        rf_addr_d    = rf_addr_q;     // address/data hold when idle
        rf_data_in_d = rf_data_in_q;
        rd_pend_d    = '0;

        if (grant_any) begin
            rf_valid_d   = req_write[grant_idx];
            rf_addr_d    = addr_arr[grant_idx];
            rf_data_in_d = wdata_arr[grant_idx];
            if (!req_write[grant_idx]) begin
                rd_pend_d = req_ready;
            end
        end

        // rf_rdata reflects the address presented this cycle, so capture it
        // only when that address belongs to a read.
        rsp_valid_d = rd_pend_q;
        rsp_data_d  = (|rd_pend_q) ? rf_rdata : rsp_data_q;
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ARB;
            ptr_q        <= LAST_IDX;
            owner_q      <= '0;
            lock_cnt_q   <= '0;
            rf_valid_q   <= 1'b0;
            rf_addr_q    <= '0;
            rf_data_in_q <= '0;
            rd_pend_q    <= '0;
            rsp_valid_q  <= '0;
            rsp_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            owner_q      <= owner_d;
            lock_cnt_q   <= lock_cnt_d;
            rf_valid_q   <= rf_valid_d;
            rf_addr_q    <= rf_addr_d;
            rf_data_in_q <= rf_data_in_d;
            rd_pend_q    <= rd_pend_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

    assign rf_valid   = rf_valid_q;
    assign rf_addr    = rf_addr_q;
    assign rf_data_in = rf_data_in_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;

endmodule
